// File: rtl/alu_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : alu_pkg
//  Purpose  : Shared opcodes, state encoding and sizing constants for the
//             ALU command engine.
//  Revision : 1.0  initial release
// ============================================================================
package alu_pkg;

   localparam int HDR_BYTES_C  = 4;
   localparam int WORD_BYTES_C = 4;

   typedef enum logic [7:0] {
      OP_ECHO = 8'hEC,
      OP_ADD  = 8'hA0,
      OP_MUL  = 8'hB0
   } opcode_e;

   typedef logic [2:0] state_e;

   localparam state_e ST_IDLE    = 3'd0;
   localparam state_e ST_HDR_RSV = 3'd1;
   localparam state_e ST_HDR_LSB = 3'd2;
   localparam state_e ST_HDR_MSB = 3'd3;
   localparam state_e ST_ECHO    = 3'd4;
   localparam state_e ST_ACC     = 3'd5;
   localparam state_e ST_SEND    = 3'd6;
   localparam state_e ST_DRAIN   = 3'd7;

endpackage
`default_nettype wire

// File: rtl/alu_word_accum.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : alu_word_accum
//  Purpose  : Assembles little-endian bytes into words and folds each word
//             into an add or multiply accumulator.
//  Revision : 1.0  initial release
// ============================================================================
module alu_word_accum
   import alu_pkg::*;
#(
   parameter int DATA_WIDTH_P = 8,
   parameter int WORD_BYTES_P = WORD_BYTES_C
) (
   input  logic                                 clk,
   input  logic                                 rst,
   input  logic                                 clr,
   input  logic                                 load,
   input  logic                                 op_mul,
   input  logic [DATA_WIDTH_P-1:0]              data,
   output logic [DATA_WIDTH_P*WORD_BYTES_P-1:0] acc,
   output logic [DATA_WIDTH_P*WORD_BYTES_P-1:0] acc_next
);

   localparam int WORD_W = DATA_WIDTH_P * WORD_BYTES_P;
   localparam int CNT_W  = $clog2(WORD_BYTES_P);

   logic [WORD_W-1:0] r_word;
   logic [WORD_W-1:0] r_acc;
   logic [CNT_W-1:0]  r_byte_cnt;
   logic              r_first;
   logic [WORD_W-1:0] w_word;
   logic              w_word_done;
   logic [WORD_W-1:0] w_acc_next;

   assign w_word      = {data, r_word[WORD_W-1:DATA_WIDTH_P]};
   assign w_word_done = load && (r_byte_cnt == CNT_W'(WORD_BYTES_P - 1));

   // The first complete word seeds the accumulator; later words fold in.
   always_comb begin
      w_acc_next = r_acc;
      if (w_word_done) begin
         if (r_first)
            w_acc_next = w_word;
         else if (op_mul)
            w_acc_next = r_acc * w_word;
         else
            w_acc_next = r_acc + w_word;
      end
   end

   always_ff @(posedge clk) begin
      if (rst || clr) begin
         r_word     <= '0;
         r_acc      <= '0;
         r_byte_cnt <= '0;
         r_first    <= 1'b1;
      end else if (load) begin
         r_word     <= w_word;
         r_byte_cnt <= r_byte_cnt + 1'b1;
         r_acc      <= w_acc_next;
         if (w_word_done)
            r_first <= 1'b0;
      end
   end

   assign acc      = r_acc;
   assign acc_next = w_acc_next;

endmodule
`default_nettype wire

// File: rtl/alu_cmd_engine.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : alu_cmd_engine
//  Purpose  : Parses byte-stream command packets and streams back echo data
//             or a 32-bit add/mul reduction of the payload words.
//  Revision : 1.0  initial release
// ============================================================================
module alu_cmd_engine
   import alu_pkg::*;
#(
   parameter int DATA_WIDTH_P = 8,
   parameter int WORD_BYTES_P = WORD_BYTES_C
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [DATA_WIDTH_P-1:0] s_axis_tdata,
   input  logic                    s_axis_tvalid,
   output logic                    s_axis_tready,
   output logic [DATA_WIDTH_P-1:0] m_axis_tdata,
   output logic                    m_axis_tvalid,
   input  logic                    m_axis_tready,
   output logic                    busy_o,
   output logic                    err_o
);

   localparam int WORD_W = DATA_WIDTH_P * WORD_BYTES_P;
   localparam int IDX_W  = $clog2(WORD_BYTES_P);

   state_e                  r_state;
   logic [DATA_WIDTH_P-1:0] r_opcode;
   logic [DATA_WIDTH_P-1:0] r_len_lsb;
   logic [15:0]             r_remain;
   logic [DATA_WIDTH_P-1:0] r_tdata;
   logic                    r_tvalid;
   logic                    r_err;
   logic [IDX_W-1:0]        r_send_idx;

   logic                    w_s_ready;
   logic                    w_in_hs;
   logic                    w_out_hs;
   logic                    w_last;
   logic [15:0]             w_len;
   logic [15:0]             w_payload;
   logic                    w_has_payload;
   logic                    w_is_echo;
   logic                    w_is_arith;
   logic                    w_valid;
   logic                    w_acc_clr;
   logic                    w_acc_load;
   logic [WORD_W-1:0]       w_acc;
   logic [WORD_W-1:0]       w_acc_next;
   logic [WORD_W-1:0]       w_result;
   logic [IDX_W-1:0]        w_next_idx;
   logic [IDX_W-1:0]        w_sel_idx;
   logic [DATA_WIDTH_P-1:0] w_out_byte;

   assign w_in_hs   = s_axis_tvalid && w_s_ready;
   assign w_out_hs  = r_tvalid && m_axis_tready;
   assign w_last    = (r_remain == 16'd1);
   assign w_len     = {s_axis_tdata, r_len_lsb};
   assign w_payload = w_len - 16'(HDR_BYTES_C);

   assign w_is_echo     = (r_opcode == OP_ECHO);
   assign w_is_arith    = (r_opcode == OP_ADD) || (r_opcode == OP_MUL);
   assign w_has_payload = (w_len > 16'(HDR_BYTES_C));
   assign w_valid       = (w_len >= 16'(HDR_BYTES_C)) &&
                          (w_is_echo ||
                           (w_is_arith &&
                            (w_len >= 16'(HDR_BYTES_C + WORD_BYTES_P)) &&
                            (w_payload % 16'(WORD_BYTES_P) == 16'd0)));

   // In IDLE a still-pending echo byte blocks the next packet's opcode.
   always_comb begin
      w_s_ready = 1'b0;
      case (r_state)
         ST_IDLE:    w_s_ready = !r_tvalid;
         ST_HDR_RSV,
         ST_HDR_LSB,
         ST_HDR_MSB,
         ST_ACC,
         ST_DRAIN:   w_s_ready = 1'b1;
         ST_ECHO:    w_s_ready = !r_tvalid || m_axis_tready;
         default:    w_s_ready = 1'b0;
      endcase
      if (rst)
         w_s_ready = 1'b0;
   end

   assign w_acc_clr  = w_in_hs && (r_state == ST_HDR_MSB);
   assign w_acc_load = w_in_hs && (r_state == ST_ACC);

   alu_word_accum #(
      .DATA_WIDTH_P (DATA_WIDTH_P),
      .WORD_BYTES_P (WORD_BYTES_P)
   ) u_accum (
      .clk      (clk),
      .rst      (rst),
      .clr      (w_acc_clr),
      .load     (w_acc_load),
      .op_mul   (r_opcode == OP_MUL),
      .data     (s_axis_tdata),
      .acc      (w_acc),
      .acc_next (w_acc_next)
   );

   // Byte 0 is taken from the in-flight result so tvalid can rise next cycle.
   assign w_result   = (r_state == ST_ACC) ? w_acc_next : w_acc;
   assign w_next_idx = r_send_idx + 1'b1;
   assign w_sel_idx  = (r_state == ST_ACC) ? '0 : w_next_idx;
   assign w_out_byte = w_result[int'(w_sel_idx)*DATA_WIDTH_P +: DATA_WIDTH_P];

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= ST_IDLE;
         r_opcode   <= '0;
         r_len_lsb  <= '0;
         r_remain   <= '0;
         r_tdata    <= '0;
         r_tvalid   <= 1'b0;
         r_err      <= 1'b0;
         r_send_idx <= '0;
      end else begin
         r_err <= 1'b0;
         if (w_out_hs && (r_state != ST_SEND))
            r_tvalid <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (w_in_hs) begin
                  r_opcode <= s_axis_tdata;
                  r_state  <= ST_HDR_RSV;
               end
            end
            ST_HDR_RSV: begin
               if (w_in_hs)
                  r_state <= ST_HDR_LSB;
            end
            ST_HDR_LSB: begin
               if (w_in_hs) begin
                  r_len_lsb <= s_axis_tdata;
                  r_state   <= ST_HDR_MSB;
               end
            end
            ST_HDR_MSB: begin
               if (w_in_hs) begin
                  r_remain <= w_has_payload ? w_payload : 16'd0;
                  if (!w_valid) begin
                     r_err   <= 1'b1;
                     r_state <= w_has_payload ? ST_DRAIN : ST_IDLE;
                  end else if (w_is_echo) begin
                     r_state <= w_has_payload ? ST_ECHO : ST_IDLE;
                  end else begin
                     r_state <= ST_ACC;
                  end
               end
            end
            ST_ECHO: begin
               if (w_in_hs) begin
                  r_tdata  <= s_axis_tdata;
                  r_tvalid <= 1'b1;
                  r_remain <= r_remain - 16'd1;
                  if (w_last)
                     r_state <= ST_IDLE;
               end
            end
            ST_ACC: begin
               if (w_in_hs) begin
                  r_remain <= r_remain - 16'd1;
                  if (w_last) begin
                     r_tdata    <= w_out_byte;
                     r_tvalid   <= 1'b1;
                     r_send_idx <= '0;
                     r_state    <= ST_SEND;
                  end
               end
            end
            ST_SEND: begin
               if (w_out_hs) begin
                  if (r_send_idx == IDX_W'(WORD_BYTES_P - 1)) begin
                     r_tvalid <= 1'b0;
                     r_state  <= ST_IDLE;
                  end else begin
                     r_send_idx <= w_next_idx;
                     r_tdata    <= w_out_byte;
                  end
               end
            end
            ST_DRAIN: begin
               if (w_in_hs) begin
                  r_remain <= r_remain - 16'd1;
                  if (w_last)
                     r_state <= ST_IDLE;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign s_axis_tready = w_s_ready;
   assign m_axis_tdata  = r_tdata;
   assign m_axis_tvalid = r_tvalid;
   assign busy_o        = (r_state != ST_IDLE);
   assign err_o         = r_err;

endmodule
`default_nettype wire

// File: tb/tb_alu_cmd_engine.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_alu_cmd_engine
//  Purpose  : Directed packet vectors and corner sequences for alu_cmd_engine.
//  Revision : 1.0  initial release
// ============================================================================
module tb_alu_cmd_engine;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] s_axis_tdata = 8'h00;
   logic       s_axis_tvalid = 1'b0;
   logic       s_axis_tready;
   logic [7:0] m_axis_tdata;
   logic       m_axis_tvalid;
   logic       m_axis_tready = 1'b1;
   logic       busy_o;
   logic       err_o;

   alu_cmd_engine #(
      .DATA_WIDTH_P (8),
      .WORD_BYTES_P (4)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .s_axis_tdata  (s_axis_tdata),
      .s_axis_tvalid (s_axis_tvalid),
      .s_axis_tready (s_axis_tready),
      .m_axis_tdata  (m_axis_tdata),
      .m_axis_tvalid (m_axis_tvalid),
      .m_axis_tready (m_axis_tready),
      .busy_o        (busy_o),
      .err_o         (err_o)
   );

   always #5 clk = ~clk;

   typedef struct {
      string        name;
      logic [127:0] in_data;   // right-aligned, first byte most significant
      int           n_in;
      logic [31:0]  exp_data;  // right-aligned, first byte most significant
      int           n_exp;
      int           exp_err;
      bit           toggle;
   } vec_t;

   int         checks = 0;
   int         errors = 0;
   logic [7:0] out_q[$];
   int         err_seen = 0;
   int         tready_mode = 0;  // 0: held high, 1: toggling, 2: manual
   vec_t       vecs[11];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Output handshakes and error pulses, observed mid-cycle.
   initial begin
      forever begin
         @(negedge clk);
         if (!rst && m_axis_tvalid && m_axis_tready)
            out_q.push_back(m_axis_tdata);
         if (err_o)
            err_seen++;
      end
   end

   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (tready_mode == 0)
            m_axis_tready = 1'b1;
         else if (tready_mode == 1)
            m_axis_tready = ~m_axis_tready;
      end
   end

   // Called just after a rising edge; returns just after the accepting edge.
   task automatic send_byte(input logic [7:0] b);
      bit done = 1'b0;
      s_axis_tdata  = b;
      s_axis_tvalid = 1'b1;
      for (int k = 0; k < 200; k++) begin
         @(negedge clk);
         if (s_axis_tready) done = 1'b1;
         @(posedge clk);
         #1;
         if (done) break;
      end
      s_axis_tvalid = 1'b0;
      if (!done) check("send_timeout", 32'd0, 32'd1);
   endtask

   task automatic wait_idle();
      bit done = 1'b0;
      for (int k = 0; k < 500; k++) begin
         @(negedge clk);
         if (!busy_o && !m_axis_tvalid) begin
            done = 1'b1;
            break;
         end
      end
      if (!done) check("idle_timeout", 32'd0, 32'd1);
      repeat (2) @(posedge clk);
      #1;
   endtask

   task automatic run_vec(input vec_t v);
      tready_mode = v.toggle ? 1 : 0;
      out_q.delete();
      err_seen = 0;
      for (int i = 0; i < v.n_in; i++)
         send_byte(v.in_data[8*(v.n_in-1-i) +: 8]);
      wait_idle();
      tready_mode = 0;
      check({v.name, "_count"}, 32'(out_q.size()), 32'(v.n_exp));
      for (int j = 0; j < v.n_exp; j++)
         check($sformatf("%s_byte%0d", v.name, j),
               (j < out_q.size()) ? {24'h0, out_q[j]} : 32'hxxxxxxxx,
               {24'h0, v.exp_data[8*(v.n_exp-1-j) +: 8]});
      check({v.name, "_err"}, 32'(err_seen), 32'(v.exp_err));
      check({v.name, "_busy"}, {31'h0, busy_o}, 32'd0);
   endtask

   initial begin
      vecs[0]  = '{"add3",      128'hA0001000_01000000_02000000_03000000, 16, 32'h06000000, 4, 0, 1'b0};
      vecs[1]  = '{"mul_wrap",  128'hB0000C00_FFFFFFFF_02000000,          12, 32'hFEFFFFFF, 4, 0, 1'b0};
      vecs[2]  = '{"echo_bp",   128'hEC000700_414243,                      7, 32'h00414243, 3, 0, 1'b1};
      vecs[3]  = '{"bad_op",    128'h55000800_11223344,                    8, 32'h0,        0, 1, 1'b0};
      vecs[4]  = '{"recover",   128'hA0000800_78563412,                    8, 32'h78563412, 4, 0, 1'b0};
      vecs[5]  = '{"bad_len",   128'hA0000A00_010203040506,               10, 32'h0,        0, 1, 1'b0};
      vecs[6]  = '{"echo_len4", 128'hEC000400,                             4, 32'h0,        0, 0, 1'b0};
      vecs[7]  = '{"short_len", 128'hA0000200,                             4, 32'h0,        0, 1, 1'b0};
      vecs[8]  = '{"mul3",      128'hB0001000_03000000_05000000_07000000, 16, 32'h69000000, 4, 0, 1'b0};
      vecs[9]  = '{"echo2",     128'hEC000600_AA55,                        6, 32'h0000AA55, 2, 0, 1'b0};
      vecs[10] = '{"add_len4",  128'hA0000400,                             4, 32'h0,        0, 1, 1'b0};

      // Reset values
      repeat (3) @(posedge clk);
      #1;
      check("rst_s_tready", {31'h0, s_axis_tready}, 32'd0);
      check("rst_m_tvalid", {31'h0, m_axis_tvalid}, 32'd0);
      check("rst_m_tdata",  {24'h0, m_axis_tdata},  32'd0);
      check("rst_busy",     {31'h0, busy_o},        32'd0);
      check("rst_err",      {31'h0, err_o},         32'd0);
      rst = 1'b0;
      #1;
      check("idle_s_tready", {31'h0, s_axis_tready}, 32'd1);

      foreach (vecs[v])
         run_vec(vecs[v]);

      // Reset while two result bytes of four have left
      tready_mode   = 2;
      m_axis_tready = 1'b0;
      out_q.delete();
      err_seen = 0;
      send_byte(8'hA0); send_byte(8'h00); send_byte(8'h08); send_byte(8'h00);
      send_byte(8'h01); send_byte(8'h02); send_byte(8'h03); send_byte(8'h04);
      check("send_tvalid", {31'h0, m_axis_tvalid}, 32'd1);
      check("send_byte0",  {24'h0, m_axis_tdata},  32'h01);
      check("send_s_tready", {31'h0, s_axis_tready}, 32'd0);
      m_axis_tready = 1'b1;
      repeat (2) begin
         @(posedge clk);
         #1;
      end
      m_axis_tready = 1'b0;
      rst = 1'b1;
      #1;
      check("rstmid_s_tready", {31'h0, s_axis_tready}, 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      check("rstmid_tvalid", {31'h0, m_axis_tvalid}, 32'd0);
      check("rstmid_busy",   {31'h0, busy_o},        32'd0);
      check("rstmid_tdata",  {24'h0, m_axis_tdata},  32'd0);
      check("rstmid_count",  32'(out_q.size()),      32'd2);
      tready_mode = 0;
      run_vec('{"post_rst", 128'hA0000C00_10000000_05000000, 12, 32'h15000000, 4, 0, 1'b0});

      // Maximum length: invalid opcode drains 0xFFFB bytes
      out_q.delete();
      err_seen = 0;
      send_byte(8'h00); send_byte(8'h00); send_byte(8'hFF); send_byte(8'hFF);
      for (int i = 0; i < 65530; i++)
         send_byte(8'(i));
      check("maxlen_busy_before", {31'h0, busy_o}, 32'd1);
      send_byte(8'h5A);
      check("maxlen_busy_after",  {31'h0, busy_o}, 32'd0);
      wait_idle();
      check("maxlen_err",   32'(err_seen),     32'd1);
      check("maxlen_count", 32'(out_q.size()), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
